// File: rtl/mem_arbiter.sv
// Two-master memory arbiter with round-robin tie-break and an in-order
// owner-tag FIFO that routes read data back to the master that issued the read.
module mem_arbiter #(
  parameter int unsigned MAX_RD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] i_m0_addr,
  input  logic        i_m0_rd,
  input  logic        i_m0_wr,
  input  logic [15:0] i_m0_wrdata,
  output logic        o_m0_wait,
  output logic [15:0] o_m0_rddata,
  output logic        o_m0_rddatavalid,
  input  logic [15:0] i_m1_addr,
  input  logic        i_m1_rd,
  input  logic        i_m1_wr,
  input  logic [15:0] i_m1_wrdata,
  output logic        o_m1_wait,
  output logic [15:0] o_m1_rddata,
  output logic        o_m1_rddatavalid,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_wrdata,
  input  logic        i_mem_wait,
  input  logic [15:0] i_mem_rddata,
  input  logic        i_mem_rddatavalid,
  output logic        o_rd_err
);

  localparam int unsigned PW = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t            state;
  logic              last_owner;
  logic [MAX_RD-1:0] tags;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic req0, req1;
  logic fifo_empty, fifo_full;
  logic pop, push, rd_stall, accept;
  logic head_tag;

  assign req0       = i_m0_rd | i_m0_wr;
  assign req1       = i_m1_rd | i_m1_wr;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(MAX_RD));
  assign pop        = i_mem_rddatavalid & ~fifo_empty;
  // A pop in the same cycle frees a slot, so a full FIFO only blocks reads without one.
  assign rd_stall   = fifo_full & ~pop;
  assign head_tag   = tags[rd_ptr];

  always_comb begin
    o_mem_addr   = '0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_wrdata = '0;
    case (state)
      GRANT0: begin
        o_mem_addr   = i_m0_addr;
        o_mem_rd     = i_m0_rd & ~rd_stall;
        o_mem_wr     = i_m0_wr & ~i_m0_rd;
        o_mem_wrdata = i_m0_wrdata;
      end
      GRANT1: begin
        o_mem_addr   = i_m1_addr;
        o_mem_rd     = i_m1_rd & ~rd_stall;
        o_mem_wr     = i_m1_wr & ~i_m1_rd;
        o_mem_wrdata = i_m1_wrdata;
      end
      default: ;
    endcase
  end

  assign accept = (state != IDLE) & (o_mem_rd | o_mem_wr) & ~i_mem_wait;
  assign push   = accept & o_mem_rd;

  assign o_m0_wait = req0 & ~(accept & (state == GRANT0));
  assign o_m1_wait = req1 & ~(accept & (state == GRANT1));

  assign o_m0_rddata      = i_mem_rddata;
  assign o_m1_rddata      = i_mem_rddata;
  assign o_m0_rddatavalid = pop & ~head_tag;
  assign o_m1_rddatavalid = pop & head_tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && req1)  state <= last_owner ? GRANT0 : GRANT1;
          else if (req0)     state <= GRANT0;
          else if (req1)     state <= GRANT1;
        end
        GRANT0: begin
          if (accept) begin
            last_owner <= 1'b0;
            if (req1)      state <= GRANT1;
            else if (req0) state <= GRANT0;
            else           state <= IDLE;
          end else if (!req0) begin
            state <= IDLE;
          end
        end
        GRANT1: begin
          if (accept) begin
            last_owner <= 1'b1;
            if (req0)      state <= GRANT0;
            else if (req1) state <= GRANT1;
            else           state <= IDLE;
          end else if (!req1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tags     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      o_rd_err <= 1'b0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= (state == GRANT1);
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (i_mem_rddatavalid && fifo_empty) o_rd_err <= 1'b1;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_RD, default 4, giving the maximum number of outstanding reads (a power of 2, at least 2).
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- i_m0_addr / i_m1_addr  in  16  master 0 (CPU) and master 1 (I/O) address.
- i_m0_rd / i_m1_rd  in  1  read request.
- i_m0_wr / i_m1_wr  in  1  write request.
- i_m0_wrdata / i_m1_wrdata  in  16  write data.
- o_m0_wait / o_m1_wait  out  1  request not accepted this cycle; the master holds its request stable.
- o_m0_rddata / o_m1_rddata  out  16  both equal i_mem_rddata.
- o_m0_rddatavalid / o_m1_rddatavalid  out  1  read data for that master is valid.
- o_mem_addr  out  16  shared memory address.
- o_mem_rd  out  1  shared memory read strobe.
- o_mem_wr  out  1  shared memory write strobe.
- o_mem_wrdata  out  16  shared memory write data.
- i_mem_wait  in  1  memory stall.
- i_mem_rddata  in  16  memory read data.
- i_mem_rddatavalid  in  1  memory read data valid; reads return in issue order.
- o_rd_err  out  1  sticky flag: rddatavalid arrived with no read outstanding.

Function
REQ-003 The FSM SHALL have three states: IDLE, GRANT0 and GRANT1.
REQ-004 A master SHALL be requesting when its rd or wr input is 1; rd and wr both 1 SHALL be treated as a read.
REQ-005 In IDLE, o_mem_rd and o_mem_wr SHALL be 0, o_mem_addr and o_mem_wrdata SHALL be 0, and each requesting master SHALL see wait=1.
REQ-006 From IDLE, the next state SHALL be:
- GRANTn when only master n is requesting;
- when both are requesting, the grant of the master not served last (register last_owner);
- otherwise IDLE.
REQ-007 In GRANTn, master n's addr, rd, wr and wrdata SHALL drive the memory port combinationally.
REQ-008 In GRANTn, the other master's wait SHALL be 1 whenever it is requesting.
REQ-009 A transfer SHALL be accepted in a cycle where the state is GRANTn, o_mem_rd or o_mem_wr is 1, and i_mem_wait is 0; in that cycle o_mn_wait SHALL be 0.
REQ-010 While not accepted, o_mn_wait SHALL equal 1 whenever master n is requesting.
REQ-011 On acceptance, last_owner SHALL become n, and the next state SHALL be:
- GRANT(other) when the other master is requesting;
- else GRANTn when master n is still requesting (back-to-back);
- else IDLE.
REQ-012 In GRANTn, if master n drops its request without acceptance, the FSM SHALL return to IDLE next cycle.
REQ-013 Grant SHALL never change while i_mem_wait holds an issued request.
REQ-014 An owner-tag FIFO of depth MAX_RD SHALL push tag n on each accepted read and pop on each i_mem_rddatavalid; push and pop in the same cycle SHALL leave the count unchanged.
REQ-015 When the FIFO count equals MAX_RD and there is no pop this cycle, a granted read SHALL be stalled: o_mem_rd=0 and o_mn_wait=1. Writes SHALL NOT be stalled by this condition.
REQ-016 o_mn_rddatavalid SHALL equal i_mem_rddatavalid AND (head tag == n), in the same cycle (zero latency).
REQ-017 When i_mem_rddatavalid is 1 with the FIFO empty, both rddatavalid outputs SHALL be 0, the FIFO SHALL not change, and o_rd_err SHALL be set to 1 until reset.
REQ-018 FIFO pointers SHALL wrap modulo MAX_RD; the count SHALL range 0..MAX_RD.
REQ-019 Arbitration latency SHALL be 1 cycle from IDLE; throughput SHALL be 1 transfer per cycle with no memory wait.

Reset
REQ-020 On reset: state=IDLE, last_owner=1 (so master 0 wins the first tie), FIFO empty, o_rd_err=0, all memory strobes 0.
REQ-021 Reset asserted mid-transfer SHALL abort the transfer and discard all outstanding tags; rddatavalid arriving after reset with the FIFO empty SHALL set o_rd_err.

Verification
REQ-022 Both masters read at cycle 0 after reset -> GRANT0 at cycle 1, m0 accepted; GRANT1 at cycle 2; i_mem_rddatavalid on two later cycles -> o_m0_rddatavalid, then o_m1_rddatavalid.
REQ-023 m1 writes addr 0x0040, data 0xBEEF, with i_mem_wait=1 for 3 cycles -> o_mem_addr=0x0040 and o_mem_wrdata=0xBEEF held stable, o_m1_wait=1 for 3 cycles, then 0, exactly one write.
REQ-024 m0 issues 5 reads back-to-back with no rddatavalid (MAX_RD=4) -> 4 accepted, 5th stalled with o_mem_rd=0 and wait=1; one rddatavalid -> 5th accepted the same cycle.
REQ-025 Both masters request continuously for 8 transfers -> grants alternate 0,1,0,1, with 4 acceptances each.
REQ-026 i_mem_rddatavalid pulsed with no reads outstanding -> no rddatavalid to either master, o_rd_err=1 and held until reset.
REQ-027 Reset asserted with 2 reads outstanding -> state IDLE, FIFO empty, o_mem_rd=0 on the next cycle.
